adapter_ppfifo_2_axi_stream_wl: RTL

// Read-side adapter: drains a Ping Pong FIFO read controller and emits an AXI Stream master.

---
 rtl/adapter_ppfifo_2_axi_stream_wl_pkg.sv | 25 ++
 rtl/adapter_ppfifo_2_axi_stream_wl_axis_out_stage.sv | 61 ++++++
 rtl/adapter_ppfifo_2_axi_stream_wl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/adapter_ppfifo_2_axi_stream_wl_pkg.sv
// Shared types and constants for the PPFIFO-to-AXI-Stream read adapter.
// Holds the FSM encoding, the PPFIFO size width and the tag-bit helpers.
package adapter_ppfifo_2_axi_stream_wl_pkg;

    localparam int PPFIFO_SIZE_W = 24;
    localparam int PIXEL_CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRAB   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } adapter_state_e;

    // The PPFIFO word carries its last tag one bit above the payload.
    function automatic int tag_bit_idx(input int data_width);
        return data_width;
    endfunction

    function automatic logic is_frame_end(input logic [PIXEL_CNT_W-1:0] pixel,
                                          input logic [PIXEL_CNT_W-1:0] frame_len);
        return (frame_len != '0) && (pixel == frame_len - 32'd1);
    endfunction

endpackage

// File: rtl/adapter_ppfifo_2_axi_stream_wl_axis_out_stage.sv
// One-entry AXI Stream output register: loads a beat when empty or draining,
// holds data/last/user stable while the sink stalls.
module adapter_ppfifo_2_axi_stream_wl_axis_out_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  user_i,
    input  logic                  ready_i,
    output logic                  can_load_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  user_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  user_q, user_d;

    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        user_d  = user_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
            user_d  = user_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign user_o  = user_q;

endmodule

// File: rtl/adapter_ppfifo_2_axi_stream_wl.sv
// Drains Ping Pong FIFO read buffers into a framed AXI Stream (tuser = SOF, tlast = EOF).
// state  | meaning
// IDLE   | waiting for i_enable; latches frame length
// GRAB   | waiting for a ready PPFIFO buffer to activate
// STREAM | popping words from the held buffer into the output stage
// DRAIN  | frame's last beat loaded; waiting for the sink to accept it
module adapter_ppfifo_2_axi_stream_wl
    import adapter_ppfifo_2_axi_stream_wl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter bit USE_LAST_TAG = 1'b1
) (
    input  logic                     i_axi_clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic [PIXEL_CNT_W-1:0]   i_pixel_count,
    output logic                     o_frame_done,
    output logic                     o_ppfifo_clk,
    input  logic                     i_ppfifo_rdy,
    output logic                     o_ppfifo_act,
    input  logic [PPFIFO_SIZE_W-1:0] i_ppfifo_size,
    input  logic [DATA_WIDTH:0]      i_ppfifo_data,
    output logic                     o_ppfifo_stb,
    output logic                     o_axi_valid,
    input  logic                     i_axi_ready,
    output logic [DATA_WIDTH-1:0]    o_axi_data,
    output logic [STROBE_WIDTH-1:0]  o_axi_keep,
    output logic                     o_axi_last,
    output logic                     o_axi_user
);

    localparam int TAG_IDX = tag_bit_idx(DATA_WIDTH);

    adapter_state_e           state_q, state_d;
    logic                     act_q, act_d;
    logic [PPFIFO_SIZE_W-1:0] count_q, count_d;
    logic [PIXEL_CNT_W-1:0]   pixel_q, pixel_d;
    logic [PIXEL_CNT_W-1:0]   frame_len_q, frame_len_d;
    logic                     sof_q, sof_d;
    logic                     frame_done_q, frame_done_d;

    logic can_load;
    logic pop;
    logic beat_tag;
    logic beat_last;

    assign beat_tag  = USE_LAST_TAG && i_ppfifo_data[TAG_IDX];
    assign beat_last = is_frame_end(pixel_q, frame_len_q) || beat_tag;
    assign pop       = (state_q == ST_STREAM) && act_q &&
                       (count_q < i_ppfifo_size) && can_load;

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        count_d      = count_q;
        pixel_d      = pixel_q;
        frame_len_d  = frame_len_q;
        sof_d        = sof_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    frame_len_d = i_pixel_count;
                    pixel_d     = '0;
                    sof_d       = 1'b1;
                    state_d     = ST_GRAB;
                end
            end
            ST_GRAB: begin
                if (i_ppfifo_rdy && !act_q) begin
                    act_d   = 1'b1;
                    count_d = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // An empty buffer is released immediately without any strobe.
                if (i_ppfifo_size == '0) begin
                    act_d   = 1'b0;
                    state_d = ST_GRAB;
                end else if (pop) begin
                    sof_d   = 1'b0;
                    count_d = count_q + 24'd1;
                    pixel_d = pixel_q + 32'd1;
                    if (beat_last) begin
                        act_d   = 1'b0;
                        state_d = ST_DRAIN;
                    end else if (count_q + 24'd1 == i_ppfifo_size) begin
                        act_d   = 1'b0;
                        state_d = ST_GRAB;
                    end
                end
            end
            ST_DRAIN: begin
                if (o_axi_valid && i_axi_ready && o_axi_last) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            act_q        <= 1'b0;
            count_q      <= '0;
            pixel_q      <= '0;
            frame_len_q  <= '0;
            sof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            count_q      <= count_d;
            pixel_q      <= pixel_d;
            frame_len_q  <= frame_len_d;
            sof_q        <= sof_d;
            frame_done_q <= frame_done_d;
        end
    end

    adapter_ppfifo_2_axi_stream_wl_axis_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk_i      (i_axi_clk),
        .rst_i      (rst),
        .load_i     (pop),
        .data_i     (i_ppfifo_data[DATA_WIDTH-1:0]),
        .last_i     (beat_last),
        .user_i     (sof_q),
        .ready_i    (i_axi_ready),
        .can_load_o (can_load),
        .valid_o    (o_axi_valid),
        .data_o     (o_axi_data),
        .last_o     (o_axi_last),
        .user_o     (o_axi_user)
    );

    assign o_ppfifo_clk = i_axi_clk;
    assign o_ppfifo_act = act_q;
    assign o_ppfifo_stb = pop;
    assign o_frame_done = frame_done_q;
    assign o_axi_keep   = '1;

endmodule
